// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
// Imported by the interface, the priority picker and the arbiter top.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    LS_BUSY = 2'd2,
    RESP    = 2'd3
  } arbState_e;

  typedef logic [2:0] funct3_t;

  // Encoding of the fairness bit: which requester won the last arbitration
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam funct3_t FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave = the arbiter's view, master = the core/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  funct3_t           ls_funct3;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_req;
  logic              mem_we;
  funct3_t           mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              bus_err;
  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
    input  mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
    output bus_err, busy
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
    output mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
    input  bus_err, busy
  );

endinterface

// File: rtl/mem_port_arbiter_prio_pick.sv
// Combinational two-way picker: a lone requester always wins; on contention
// the requester that did not win last time gets the port.
module arb_prio_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic last_ls,
  output logic gnt_if,
  output logic gnt_ls
);

  assign gnt_ls = ls_req && (!if_req || (last_ls == OWN_IF));
  assign gnt_if = if_req && (!ls_req || (last_ls == OWN_LS));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ready/ack memory port between instruction fetch and load/store.
// Optional bus-error abort on a silent memory: define ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
    $error("TIMEOUT_CYCLES must lie in 2..255");
  end

  arbState_e         state,     stateNext;
  logic              lastLs,    lastLsNext;
  logic              memReq,    memReqNext;
  logic              memWe,     memWeNext;
  funct3_t           memFunct3, memFunct3Next;
  logic [ADDR_W-1:0] memAddr,   memAddrNext;
  logic [DATA_W-1:0] memWdata,  memWdataNext;
  logic [DATA_W-1:0] rdata,     rdataNext;
  logic              ifRvalid,  ifRvalidNext;
  logic              lsRvalid,  lsRvalidNext;
  logic              pickIf,    pickLs;
  logic              timedOut;

  arb_prio_pick u_pick (
    .if_req  (bus.if_req),
    .ls_req  (bus.ls_req),
    .last_ls (lastLs),
    .gnt_if  (pickIf),
    .gnt_ls  (pickLs)
  );

  // Grants are the only combinational outputs and exist only in IDLE
  assign bus.if_gnt = (state == IDLE) && pickIf;
  assign bus.ls_gnt = (state == IDLE) && pickLs;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned (no latch).
    stateNext     = state;
    lastLsNext    = lastLs;
    memReqNext    = memReq;
    memWeNext     = memWe;
    memFunct3Next = memFunct3;
    memAddrNext   = memAddr;
    memWdataNext  = memWdata;
    rdataNext     = rdata;
    ifRvalidNext  = 1'b0;
    lsRvalidNext  = 1'b0;

    unique case (state)
      IDLE: begin
        if (pickLs) begin
          stateNext     = LS_BUSY;
          lastLsNext    = OWN_LS;
          memReqNext    = 1'b1;
          memWeNext     = bus.ls_we;
          memFunct3Next = bus.ls_funct3;
          memAddrNext   = bus.ls_addr;
          memWdataNext  = bus.ls_wdata;
        end else if (pickIf) begin
          stateNext     = IF_BUSY;
          lastLsNext    = OWN_IF;
          memReqNext    = 1'b1;
          memWeNext     = 1'b0;
          memFunct3Next = FUNCT3_WORD;
          memAddrNext   = bus.if_addr;
          memWdataNext  = '0;
        end
      end

      IF_BUSY, LS_BUSY: begin
        if (bus.mem_ack || timedOut) begin
          stateNext    = RESP;
          memReqNext   = 1'b0;
          ifRvalidNext = (state == IF_BUSY);
          lsRvalidNext = (state == LS_BUSY);
          // Stores and aborted transactions return zero data
          if (!bus.mem_ack || (state == LS_BUSY && memWe)) rdataNext = '0;
          else                                              rdataNext = bus.mem_rdata;
        end
      end

      RESP: stateNext = IDLE;

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastLs    <= OWN_IF;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memFunct3 <= '0;
      memAddr   <= '0;
      memWdata  <= '0;
      rdata     <= '0;
      ifRvalid  <= 1'b0;
      lsRvalid  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state     <= stateNext;
      lastLs    <= lastLsNext;
      memReq    <= memReqNext;
      memWe     <= memWeNext;
      memFunct3 <= memFunct3Next;
      memAddr   <= memAddrNext;
      memWdata  <= memWdataNext;
      rdata     <= rdataNext;
      ifRvalid  <= ifRvalidNext;
      lsRvalid  <= lsRvalidNext;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] toCnt;
  logic       busErr;
  logic       inBusy;

  assign inBusy   = (state == IF_BUSY) || (state == LS_BUSY);
  assign timedOut = (toCnt == TO_LAST);

  // Counter is zero on every BUSY entry because it clears outside BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toCnt  <= '0;
      busErr <= 1'b0;
    end else begin
      toCnt  <= (inBusy && !bus.mem_ack) ? toCnt + 8'd1 : 8'd0;
      busErr <= inBusy && !bus.mem_ack && timedOut;
    end
  end

  assign bus.bus_err = busErr;
`else
  assign timedOut    = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  assign bus.mem_req    = memReq;
  assign bus.mem_we     = memWe;
  assign bus.mem_funct3 = memFunct3;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_wdata  = memWdata;
  assign bus.if_rvalid  = ifRvalid;
  assign bus.if_rdata   = rdata;
  assign bus.ls_rvalid  = lsRvalid;
  assign bus.ls_rdata   = rdata;
  assign bus.busy       = (state != IDLE);

endmodule
